// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, mem_wren and data_type codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MEM_LD = 2'b10;
  localparam logic [1:0] MEM_ST = 2'b01;

  localparam logic [1:0] DT_W = 2'b00;
  localparam logic [1:0] DT_H = 2'b01;
  localparam logic [1:0] DT_B = 2'b10;

  // Code 2'b11 falls into the word rule, so it needs full alignment.
  function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] off);
    case (dt)
      DT_B:    return 1'b0;
      DT_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte-enables/replicated data and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_dt,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_dt,
  input  logic        i_ld_uns,
  output logic [31:0] o_ld_value
);

  logic [31:0] w_shift;

  assign o_misaligned = is_misaligned(i_st_dt, i_st_off);
  assign w_shift      = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_dt)
      DT_B: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      DT_H: begin
        o_be    = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_value = w_shift;
    case (i_ld_dt)
      DT_B:    o_ld_value = {{24{~i_ld_uns & w_shift[7]}},  w_shift[7:0]};
      DT_H:    o_ld_value = {{16{~i_ld_uns & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one req/ack data-bus transaction per access, stalling the core until done.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [1:0]    i_mem_wren,
  input  logic [1:0]    i_data_type,
  input  logic          i_unsigned,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_st_data,
  output logic          o_stall,
  output logic [31:0]   o_ld_data,
  output logic          o_ld_valid,
  output logic          o_misaligned,
  output logic          o_bus_err,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [3:0]    o_bus_be,
  output logic [31:0]   o_bus_wdata,
  input  logic          i_bus_ack,
  input  logic [31:0]   i_bus_rdata
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_e        r_state, w_next;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [1:0]    r_off;
  logic [1:0]    r_dt;
  logic          r_uns;
  logic          r_err;
  logic [31:0]   r_ld_data;

  logic          w_is_load;
  logic          w_access;
  logic          w_mis;
  logic          w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ld_ext;

  assign w_is_load = (i_mem_wren == MEM_LD);
  // Requests are masked during reset so the combinational pulses stay quiet too.
  assign w_access  = !i_reset && (w_is_load || i_mem_wren == MEM_ST);
  assign w_timeout = (r_cnt == CNT_LIMIT) && !i_bus_ack;

  lsu_align u_align (
    .i_st_off     (i_addr[1:0]),
    .i_st_dt      (i_data_type),
    .i_st_data    (i_st_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .i_rdata      (i_bus_rdata),
    .i_ld_off     (r_off),
    .i_ld_dt      (r_dt),
    .i_ld_uns     (r_uns),
    .o_ld_value   (w_ld_ext)
  );

  always_comb begin
    w_next       = r_state;
    o_stall      = 1'b0;
    o_ld_valid   = 1'b0;
    o_misaligned = 1'b0;
    o_bus_err    = 1'b0;
    o_ld_data    = r_ld_data;
    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_mis) begin
            o_misaligned = 1'b1;
            if (w_is_load) begin
              o_ld_valid = 1'b1;
              o_ld_data  = '0;
            end
          end else begin
            o_stall = 1'b1;
            w_next  = BUSY;
          end
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_bus_ack || w_timeout) w_next = DONE;
      end
      DONE: begin
        o_ld_valid = !r_we;
        o_bus_err  = r_err;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The bus side is quiet outside BUSY, which also covers reset and abort.
  assign o_bus_req   = (r_state == BUSY);
  assign o_bus_we    = o_bus_req & r_we;
  assign o_bus_be    = o_bus_req ? r_be    : 4'b0000;
  assign o_bus_addr  = o_bus_req ? r_addr  : '0;
  assign o_bus_wdata = o_bus_req ? r_wdata : '0;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_off     <= '0;
      r_dt      <= '0;
      r_uns     <= 1'b0;
      r_err     <= 1'b0;
      r_ld_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_access && !w_mis) begin
            r_addr  <= {i_addr[AW-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_we    <= !w_is_load;
            r_off   <= i_addr[1:0];
            r_dt    <= i_data_type;
            r_uns   <= i_unsigned;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end else if (w_access && w_is_load) begin
            r_ld_data <= '0;
          end
        end
        BUSY: begin
          if (i_bus_ack) begin
            if (!r_we) r_ld_data <= w_ld_ext;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we) r_ld_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE:    r_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
